// File: rtl/crc_lut_arb_if.sv
// Bus bundle for crc_lut_arb: two requester channels, the shared table port and results.
// The slave modport is the arbiter; the master side holds the requesters and the table.
interface crc_lut_arb_if;
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_data;
    logic [1:0]        req_first;
    logic [1:0]        req_last;
    logic [1:0]        req_ready;
    logic [31:0]       tab_addr;
    logic [31:0]       tab_rdata;
    logic [1:0]        res_valid;
    logic [1:0][31:0]  res_crc;
    logic              busy;

    modport master (
        output req_valid, req_data, req_first, req_last, tab_rdata,
        input  req_ready, tab_addr, res_valid, res_crc, busy
    );

    modport slave (
        input  req_valid, req_data, req_first, req_last, tab_rdata,
        output req_ready, tab_addr, res_valid, res_crc, busy
    );
endinterface

// File: rtl/crc_lut_arb.sv
// Two-channel reflected CRC-32 engine sharing one 256x32 lookup table, round-robin per word.
// Define CRC_LUT_PIPE_EN when the table has a registered output (two cycles per byte).
module crc_lut_arb #(
    parameter logic [31:0] INIT_VAL = 32'hFFFF_FFFF,
    parameter logic [31:0] XOR_OUT  = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    crc_lut_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BYTE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [1:0]       bc_r;
    logic             g_r;
    logic             last_r;
    logic             last_grant_r;
    logic             busy_r;
    logic [31:0]      sh_r;
    logic [1:0][31:0] acc_r;
    logic [1:0][31:0] res_crc_r;
    logic [1:0]       res_valid_r;
    logic             grant_s;
    logic             gsel_s;
    logic             step_s;
    logic [31:0]      acc_cur_s;
    logic [31:0]      acc_next_s;
    logic [7:0]       idx_s;
`ifdef CRC_LUT_PIPE_EN
    logic             ph_r;
`endif

    // Round-robin pick: on contention the channel not served last wins.
    always_comb begin
        gsel_s = 1'b0;
        if (bus.req_valid == 2'b11) begin
            gsel_s = ~last_grant_r;
        end else if (bus.req_valid[1]) begin
            gsel_s = 1'b1;
        end else begin
            gsel_s = 1'b0;
        end
    end

    assign grant_s       = (state_r == IDLE) && (bus.req_valid != 2'b00) && !rst;
    assign bus.req_ready = grant_s ? (gsel_s ? 2'b10 : 2'b01) : 2'b00;

    assign acc_cur_s    = acc_r[g_r];
    assign idx_s        = acc_cur_s[7:0] ^ sh_r[7:0];
    assign acc_next_s   = (acc_cur_s >> 5'd8) ^ bus.tab_rdata;
    assign bus.tab_addr = (state_r == BYTE) ? {24'h00_0000, idx_s} : 32'h0000_0000;

`ifdef CRC_LUT_PIPE_EN
    // Registered table: address issued in phase 0, data consumed in phase 1.
    assign step_s = (state_r == BYTE) && ph_r;
`else
    assign step_s = (state_r == BYTE);
`endif

    assign bus.busy      = busy_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_crc   = res_crc_r;

    // Next-state decode for the word sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_s = BYTE;
                end else begin
                    state_s = IDLE;
                end
            end
            BYTE: begin
                if (step_s && (bc_r == 2'd3)) begin
                    state_s = DONE;
                end else begin
                    state_s = BYTE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state, word context, per-channel accumulators and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            bc_r         <= 2'd0;
            g_r          <= 1'b0;
            last_r       <= 1'b0;
            last_grant_r <= 1'b1;
            busy_r       <= 1'b0;
            sh_r         <= 32'h0000_0000;
            acc_r        <= {INIT_VAL, INIT_VAL};
            res_crc_r    <= 64'h0;
            res_valid_r  <= 2'b00;
`ifdef CRC_LUT_PIPE_EN
            ph_r         <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s != IDLE);
            res_valid_r <= 2'b00;
            if (grant_s) begin
                g_r    <= gsel_s;
                sh_r   <= bus.req_data[gsel_s];
                last_r <= bus.req_last[gsel_s];
                bc_r   <= 2'd0;
                if (bus.req_first[gsel_s]) begin
                    acc_r[gsel_s] <= INIT_VAL;
                end
            end
`ifdef CRC_LUT_PIPE_EN
            if (grant_s) begin
                ph_r <= 1'b0;
            end else if (state_r == BYTE) begin
                ph_r <= ~ph_r;
            end
`endif
            if (step_s) begin
                acc_r[g_r] <= acc_next_s;
                sh_r       <= sh_r >> 5'd8;
                bc_r       <= bc_r + 2'd1;
                // Result lands together with the DONE cycle so valid and value align.
                if ((bc_r == 2'd3) && last_r) begin
                    res_valid_r[g_r] <= 1'b1;
                    res_crc_r[g_r]   <= acc_next_s ^ XOR_OUT;
                end
            end
            if (state_r == DONE) begin
                last_grant_r <= g_r;
            end
        end
    end
endmodule

// File: tb/tb_crc_lut_arb.sv
// Directed self-checking bench for crc_lut_arb with a behavioural CRC-32 table model.
module tb_crc_lut_arb;
`ifdef CRC_LUT_PIPE_EN
    localparam int PER = 10;
    localparam int NL  = 8;
`else
    localparam int PER = 6;
    localparam int NL  = 4;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [31:0] hold_exp;

    logic [1:0]       tr_rdy  [0:15];
    logic [31:0]      tr_addr [0:15];
    logic [1:0]       tr_rv   [0:15];
    logic             tr_busy [0:15];
    logic [1:0][31:0] tr_crc  [0:15];

    crc_lut_arb_if bus_if ();

    crc_lut_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tab_fn(input logic [7:0] i);
        logic [31:0] c;
        c = {24'h00_0000, i};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    // Bitwise reference: four bytes LSB first into a running CRC register.
    function automatic logic [31:0] crc_word(input logic [31:0] acc, input logic [31:0] w);
        logic [31:0] c;
        c = acc;
        for (int k = 0; k < 4; k++) begin
            c = c ^ {24'h00_0000, w[8*k +: 8]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

`ifdef CRC_LUT_PIPE_EN
    initial bus_if.tab_rdata = 32'h0;
    always @(posedge clk) bus_if.tab_rdata <= tab_fn(bus_if.tab_addr[7:0]);
`else
    assign bus_if.tab_rdata = tab_fn(bus_if.tab_addr[7:0]);
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic snap(input int k);
        tr_rdy[k]  = bus_if.req_ready;
        tr_addr[k] = bus_if.tab_addr;
        tr_rv[k]   = bus_if.res_valid;
        tr_busy[k] = bus_if.busy;
        tr_crc[k]  = bus_if.res_crc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(negedge clk); #1; end
        rst = 1'b0;
    endtask

    // Present one word, wait for its grant (cycle T), then trace T .. T+PER.
    task automatic issue(input int ch, input logic [31:0] d, input logic f, input logic l,
                         output bit ok);
        bus_if.req_valid[ch] = 1'b1;
        bus_if.req_data[ch]  = d;
        bus_if.req_first[ch] = f;
        bus_if.req_last[ch]  = l;
        #1;
        ok = bus_if.req_ready[ch];
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk); #1;
            ok = bus_if.req_ready[ch];
        end
        snap(0);
        for (int k = 1; k <= PER; k++) begin
            @(negedge clk); #1;
            snap(k);
            if (k == 1) bus_if.req_valid[ch] = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus_if.req_ready !== 2'b00) begin miscompares++; $display("FAIL rst_ready: got %b want 00", bus_if.req_ready); end
        vectors++; if (bus_if.res_valid !== 2'b00) begin miscompares++; $display("FAIL rst_res_valid: got %b want 00", bus_if.res_valid); end
        vectors++; if (bus_if.res_crc !== 64'h0) begin miscompares++; $display("FAIL rst_res_crc: got %h want 0", bus_if.res_crc); end
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus_if.busy); end
        vectors++; if (bus_if.tab_addr !== 32'h0) begin miscompares++; $display("FAIL rst_tab_addr: got %h want 0", bus_if.tab_addr); end
    endtask

    task automatic test_single_ones();
        bit ok;
        logic exp_busy;
        issue(0, 32'hFFFF_FFFF, 1'b1, 1'b1, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL ones_grant: got %b want 1", ok); end
        for (int k = 1; k <= NL; k++) begin
            vectors++; if (tr_addr[k] !== 32'h0) begin miscompares++; $display("FAIL ones_addr[%0d]: got %h want 0", k, tr_addr[k]); end
        end
        for (int k = 0; k <= PER; k++) begin
            exp_busy = (k >= 1) && (k <= NL + 1);
            vectors++; if (tr_busy[k] !== exp_busy) begin miscompares++; $display("FAIL ones_busy[%0d]: got %b want %b", k, tr_busy[k], exp_busy); end
        end
        vectors++; if (tr_rv[NL] !== 2'b00) begin miscompares++; $display("FAIL ones_rv_early: got %b want 00", tr_rv[NL]); end
        vectors++; if (tr_rv[NL+1] !== 2'b01) begin miscompares++; $display("FAIL ones_rv: got %b want 01", tr_rv[NL+1]); end
        vectors++; if (tr_rv[PER] !== 2'b00) begin miscompares++; $display("FAIL ones_rv_pulse: got %b want 00", tr_rv[PER]); end
        vectors++; if (tr_crc[NL+1][0] !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL ones_crc: got %h want ffffffff", tr_crc[NL+1][0]); end
    endtask

    task automatic test_addr_seq();
        bit ok;
        logic [31:0] acc;
        logic [31:0] sh;
        logic [31:0] ea;
        int ci;
        issue(1, 32'h0000_0000, 1'b1, 1'b1, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL seq_grant: got %b want 1", ok); end
        vectors++; if (tr_addr[1] !== 32'h0000_00FF) begin miscompares++; $display("FAIL seq_addr0: got %h want 000000ff", tr_addr[1]); end
        acc = 32'hFFFF_FFFF;
        sh  = 32'h0000_0000;
        for (int b = 0; b < 4; b++) begin
            ea = {24'h00_0000, acc[7:0] ^ sh[7:0]};
            for (int r = 0; r < NL / 4; r++) begin
                ci = 1 + b * (NL / 4) + r;
                vectors++; if (tr_addr[ci] !== ea) begin miscompares++; $display("FAIL seq_addr[%0d]: got %h want %h", ci, tr_addr[ci], ea); end
            end
            acc = (acc >> 8) ^ tab_fn(ea[7:0]);
            sh  = sh >> 8;
        end
        vectors++; if (tr_rv[NL+1] !== 2'b10) begin miscompares++; $display("FAIL seq_rv: got %b want 10", tr_rv[NL+1]); end
        vectors++; if (tr_crc[NL+1][1] !== 32'h2144_DF1C) begin miscompares++; $display("FAIL seq_crc: got %h want 2144df1c", tr_crc[NL+1][1]); end
        vectors++; if (tr_crc[PER][0] !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL seq_hold_ch0: got %h want ffffffff", tr_crc[PER][0]); end
    endtask

    task automatic test_contention();
        int gch [0:7];
        int gcy [0:7];
        int ng;
        do_reset();
        ng = 0;
        bus_if.req_valid = 2'b11;
        bus_if.req_first = 2'b11;
        bus_if.req_last  = 2'b11;
        bus_if.req_data[0] = 32'h1111_1111;
        bus_if.req_data[1] = 32'h2222_2222;
        for (int n = 0; n <= 4 * PER; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            if (bus_if.req_ready == 2'b11) begin
                vectors++; miscompares++; $display("FAIL cont_overlap: got 11 want one-hot at cycle %0d", n);
            end else if (bus_if.req_ready != 2'b00 && ng < 8) begin
                gch[ng] = bus_if.req_ready[1] ? 1 : 0;
                gcy[ng] = n;
                ng++;
            end
        end
        @(negedge clk); #1;
        bus_if.req_valid = 2'b00;
        repeat (PER) @(negedge clk);
        #1;
        vectors++; if (ng !== 5) begin miscompares++; $display("FAIL cont_count: got %0d want 5", ng); end
        for (int i = 0; i < ng && i < 5; i++) begin
            vectors++; if (gch[i] !== (i % 2)) begin miscompares++; $display("FAIL cont_ch[%0d]: got %0d want %0d", i, gch[i], i % 2); end
            vectors++; if (gcy[i] !== i * PER) begin miscompares++; $display("FAIL cont_cycle[%0d]: got %0d want %0d", i, gcy[i], i * PER); end
        end
    endtask

    task automatic test_interleave();
        logic [31:0] wa [0:2];
        logic [31:0] wb [0:2];
        logic [31:0] exp_a, exp_b, got_a, got_b;
        int idx [0:1];
        int nres [0:1];
        logic [1:0] pend;
        wa[0] = 32'h0403_0201; wa[1] = 32'h0807_0605; wa[2] = 32'h0C0B_0A09;
        wb[0] = 32'hDEAD_BEEF; wb[1] = 32'h0123_4567; wb[2] = 32'h89AB_CDEF;
        exp_a = 32'hFFFF_FFFF;
        exp_b = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            exp_a = crc_word(exp_a, wa[i]);
            exp_b = crc_word(exp_b, wb[i]);
        end
        exp_a = exp_a ^ 32'hFFFF_FFFF;
        exp_b = exp_b ^ 32'hFFFF_FFFF;
        got_a = 32'h0; got_b = 32'h0;
        idx[0] = 0; idx[1] = 0; nres[0] = 0; nres[1] = 0; pend = 2'b00;
        bus_if.req_data[0] = wa[0];
        bus_if.req_data[1] = wb[0];
        bus_if.req_first = 2'b11;
        bus_if.req_last  = 2'b00;
        bus_if.req_valid = 2'b11;
        for (int n = 0; n < 200 && !(nres[0] > 0 && nres[1] > 0); n++) begin
            if (n > 0) @(negedge clk);
            // A word granted last cycle is already captured, so the next one may be shown.
            for (int c = 0; c < 2; c++) begin
                if (pend[c]) begin
                    idx[c]++;
                    if (idx[c] >= 3) begin
                        bus_if.req_valid[c] = 1'b0;
                    end else begin
                        bus_if.req_data[c]  = (c == 0) ? wa[idx[c]] : wb[idx[c]];
                        bus_if.req_first[c] = 1'b0;
                        bus_if.req_last[c]  = (idx[c] == 2);
                    end
                end
            end
            #1;
            if (bus_if.res_valid[0]) begin got_a = bus_if.res_crc[0]; nres[0]++; end
            if (bus_if.res_valid[1]) begin got_b = bus_if.res_crc[1]; nres[1]++; end
            pend = bus_if.req_ready;
        end
        bus_if.req_valid = 2'b00;
        vectors++; if (nres[0] !== 1) begin miscompares++; $display("FAIL il_count0: got %0d want 1", nres[0]); end
        vectors++; if (nres[1] !== 1) begin miscompares++; $display("FAIL il_count1: got %0d want 1", nres[1]); end
        vectors++; if (got_a !== exp_a) begin miscompares++; $display("FAIL il_crc0: got %h want %h", got_a, exp_a); end
        vectors++; if (got_b !== exp_b) begin miscompares++; $display("FAIL il_crc1: got %h want %h", got_b, exp_b); end
        repeat (PER) @(negedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [1:0] rv_seen;
        logic busy_seen;
        logic [31:0] addr_seen;
        logic [31:0] e;
        bus_if.req_valid[0] = 1'b1;
        bus_if.req_data[0]  = 32'hA5A5_5A5A;
        bus_if.req_first[0] = 1'b1;
        bus_if.req_last[0]  = 1'b1;
        #1;
        ok = bus_if.req_ready[0];
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk); #1;
            ok = bus_if.req_ready[0];
        end
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rm_grant: got %b want 1", ok); end
        @(negedge clk); #1;
        bus_if.req_valid[0] = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy: got %b want 0", bus_if.busy); end
        vectors++; if (bus_if.tab_addr !== 32'h0) begin miscompares++; $display("FAIL rm_tab_addr: got %h want 0", bus_if.tab_addr); end
        vectors++; if (bus_if.res_crc !== 64'h0) begin miscompares++; $display("FAIL rm_res_crc: got %h want 0", bus_if.res_crc); end
        rv_seen = 2'b00; busy_seen = 1'b0; addr_seen = 32'h0;
        for (int n = 0; n < 12; n++) begin
            rv_seen   = rv_seen | bus_if.res_valid | bus_if.req_ready;
            busy_seen = busy_seen | bus_if.busy;
            addr_seen = addr_seen | bus_if.tab_addr;
            @(negedge clk); #1;
        end
        vectors++; if (rv_seen !== 2'b00) begin miscompares++; $display("FAIL rm_no_pulse: got %b want 00", rv_seen); end
        vectors++; if ({busy_seen, addr_seen} !== 33'h0) begin miscompares++; $display("FAIL rm_quiet: got busy %b addr %h want 0", busy_seen, addr_seen); end
        // No first flag: the accumulator must start from its reset value.
        issue(0, 32'h1122_3344, 1'b0, 1'b0, ok);
        vectors++; if (tr_rv[NL+1] !== 2'b00) begin miscompares++; $display("FAIL rm_mid_rv: got %b want 00", tr_rv[NL+1]); end
        issue(0, 32'h5566_7788, 1'b0, 1'b1, ok);
        e = crc_word(crc_word(32'hFFFF_FFFF, 32'h1122_3344), 32'h5566_7788) ^ 32'hFFFF_FFFF;
        vectors++; if (tr_rv[NL+1] !== 2'b01) begin miscompares++; $display("FAIL rm_rv: got %b want 01", tr_rv[NL+1]); end
        vectors++; if (tr_crc[NL+1][0] !== e) begin miscompares++; $display("FAIL rm_crc: got %h want %h", tr_crc[NL+1][0], e); end
        hold_exp = e;
    endtask

    task automatic test_hold();
        bus_if.req_valid = 2'b00;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk); #1;
            vectors++; if (bus_if.res_crc[0] !== hold_exp) begin miscompares++; $display("FAIL hold_crc0: got %h want %h", bus_if.res_crc[0], hold_exp); end
            vectors++; if (bus_if.res_crc[1] !== 32'h0) begin miscompares++; $display("FAIL hold_crc1: got %h want 0", bus_if.res_crc[1]); end
            vectors++; if ({bus_if.busy, bus_if.tab_addr} !== 33'h0) begin miscompares++; $display("FAIL hold_idle: got busy %b addr %h want 0", bus_if.busy, bus_if.tab_addr); end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        hold_exp = 32'h0;
        rst = 1'b1;
        bus_if.req_valid = 2'b00;
        bus_if.req_first = 2'b00;
        bus_if.req_last  = 2'b00;
        bus_if.req_data  = 64'h0;
        @(negedge clk); #1;
        test_reset();
        test_single_ones();
        test_addr_seq();
        test_contention();
        test_interleave();
        test_reset_mid();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
